// File: rtl/cipher_pkg.sv
// cipher_pkg: shared byte type, counter-block width and counter/GF helpers
package cipher_pkg;
  localparam int CB_W = 8;
  typedef logic [CB_W-1:0] byte_t;
  function automatic byte_t cb_next(byte_t c);
    return c + 8'd1;
  endfunction
  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (en && req[(int'(ptr) + k) % N]) begin
        gnt_idx = W'((int'(ptr) + k) % N);
        gnt_any = 1'b1;
      end
    gnt = gnt_any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/sbox.sv
// sbox: AES S-box as GF(2^8) inverse (x^254) followed by the affine map
module sbox
  import cipher_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);
  byte_t s, inv;
  always_comb begin
    s = din;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      inv = gf_mul(inv, s);
    end
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/stream_cipher_arbiter.sv
// stream_cipher_arbiter: round-robin sharing of one counter-mode S-box keystream across channels
module stream_cipher_arbiter
  import cipher_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   key_load,
  input  logic [N_CH*8-1:0] key,
  input  logic [N_CH*8-1:0] ptxt_char,
  input  logic [N_CH-1:0]   din_valid,
  output logic [N_CH-1:0]   din_ready,
  output logic [7:0]        ctxt_char,
  output logic [CH_W-1:0]   dout_ch,
  output logic              dout_valid,
  input  logic              dout_ready
);
  byte_t cb_q [N_CH];
  byte_t cb_d [N_CH];
  logic [CH_W-1:0] ptr_q, ptr_d, ch_q, ch_d, gnt_idx;
  byte_t ctxt_q, ctxt_d, sbox_out;
  logic valid_q, valid_d, gnt_any;
  logic [N_CH-1:0] gnt;
  rr_arbiter #(.N(N_CH)) u_arb (
    .req     (din_valid & ~key_load),
    .en      (rst_n && (!valid_q || dout_ready)),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );
  sbox u_sbox (.din(cb_q[gnt_idx]), .dout(sbox_out));
  always_comb begin
    for (int k = 0; k < N_CH; k++)
      cb_d[k] = key_load[k] ? key[k*8 +: 8] : gnt[k] ? cb_next(cb_q[k]) : cb_q[k];
    ptr_d = !gnt_any ? ptr_q : gnt_idx == CH_W'(N_CH - 1) ? '0 : gnt_idx + 1'b1;
    ctxt_d = gnt_any ? ptxt_char[int'(gnt_idx)*8 +: 8] ^ sbox_out : ctxt_q;
    ch_d = gnt_any ? gnt_idx : ch_q;
    valid_d = gnt_any || (valid_q && !dout_ready);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) cb_q[k] <= '0;
      ptr_q <= '0;
      ctxt_q <= '0;
      ch_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cb_q <= cb_d;
      ptr_q <= ptr_d;
      ctxt_q <= ctxt_d;
      ch_q <= ch_d;
      valid_q <= valid_d;
    end
  assign din_ready = gnt;
  assign ctxt_char = ctxt_q;
  assign dout_ch = ch_q;
  assign dout_valid = valid_q;
endmodule

// File: tb/tb_stream_cipher_arbiter.sv
// tb_stream_cipher_arbiter: scoreboard bench with a table-driven reference model
module tb_stream_cipher_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  logic clk = 0, rst_n = 0, dout_ready = 0, dout_valid;
  logic [N-1:0] key_load = 0, din_valid = 0, din_ready;
  logic [8*N-1:0] key = 0, ptxt_char = 0;
  logic [7:0] ctxt_char;
  logic [W-1:0] dout_ch;
  always #5 clk = ~clk;
  stream_cipher_arbiter #(.N_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key(key), .ptxt_char(ptxt_char),
    .din_valid(din_valid), .din_ready(din_ready), .ctxt_char(ctxt_char),
    .dout_ch(dout_ch), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );
  typedef struct packed {logic [7:0] c; logic [W-1:0] ch;} exp_t;
  exp_t sb[$];
  exp_t held, e;
  logic [7:0] tbl [256];
  logic [7:0] m_cb [N];
  int m_ptr = 0, checks = 0, passes = 0;
  bit m_valid = 0, vp = 0;
  function automatic void build_sbox();
    logic [7:0] p = 8'h01, q = 8'h01, x;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    tbl[0] = 8'h63;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic model_step();
    int g = -1;
    logic [N-1:0] eg;
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    if (rst_n && (!m_valid || dout_ready))
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (g < 0 && din_valid[c] && !key_load[c]) g = c;
      end
    eg = (g >= 0) ? N'(1) << g : '0;
    chk("din_ready", 32'(din_ready), 32'(eg));
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_cb[k] = 8'h00;
      m_ptr = 0;
      m_valid = 0;
    end else begin
      if (g >= 0) begin
        sb.push_back({ptxt_char[g*8 +: 8] ^ tbl[m_cb[g]], W'(g)});
        m_cb[g] = m_cb[g] + 8'd1;
        m_ptr = (g + 1) % N;
      end
      for (int k = 0; k < N; k++) if (key_load[k]) m_cb[k] = key[k*8 +: 8];
      m_valid = (g >= 0) || (m_valid && !dout_ready);
    end
  endtask
  task automatic cyc(input bit r, input logic [N-1:0] kl, input logic [8*N-1:0] k,
                     input logic [8*N-1:0] pt, input logic [N-1:0] dv, input bit rdy);
    @(negedge clk);
    #1;
    rst_n = r; key_load = kl; key = k; ptxt_char = pt; din_valid = dv; dout_ready = rdy;
    #1;
    model_step();
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset dout_valid", 32'(dout_valid), 0);
        chk("reset ctxt_char", 32'(ctxt_char), 0);
        chk("reset dout_ch", 32'(dout_ch), 0);
        vp = 0;
      end else begin
        if (dout_valid && (!vp || dout_ready)) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected output: got %0h ch %0d expected none", ctxt_char, dout_ch);
          end else begin
            e = sb.pop_front();
            chk("ctxt_char", 32'(ctxt_char), 32'(e.c));
            chk("dout_ch", 32'(dout_ch), 32'(e.ch));
          end
          held = {ctxt_char, dout_ch};
        end else if (dout_valid) chk("hold", 32'({ctxt_char, dout_ch}), 32'(held));
        vp = dout_valid;
      end
    end
  end
  initial begin
    build_sbox();
    for (int k = 0; k < N; k++) m_cb[k] = 8'h00;
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 4'h1, 32'h10, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 32'h41, 4'h1, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 4'hF, 32'hC0804000, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, $urandom, 4'hF, 1);
    cyc(1, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, $urandom, 4'h2, 0);
    cyc(1, 0, 0, $urandom, 4'h2, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 4'h4, 32'h00FE0000, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, $urandom, 4'h4, 1);
    cyc(1, 4'h2, 32'h00005500, $urandom, 4'h6, 1);
    cyc(1, 0, 0, $urandom, 4'h2, 1);
    cyc(1, 0, 0, $urandom, 4'h1, 1);
    cyc(0, 0, 0, $urandom, 4'hF, 0);
    cyc(0, 0, 0, $urandom, 4'hF, 1);
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      logic [N-1:0] kl;
      for (int k = 0; k < N; k++) kl[k] = ($urandom % 8 == 0);
      cyc($urandom % 80 != 0, kl, {$urandom, $urandom} >> 32, $urandom, N'($urandom), $urandom % 4 != 0);
    end
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
